// File: rtl/counter_pkg.sv
// Shared definitions for the N-channel timer/counter: mode encodings,
// control-register bit positions and the per-channel state type.
package counter_pkg;

    localparam logic [1:0] MODE_ONESHOT  = 2'd0;
    localparam logic [1:0] MODE_PERIODIC = 2'd1;
    localparam logic [1:0] MODE_SQUARE   = 2'd2;
    localparam logic [1:0] MODE_STOP     = 2'd3;

    localparam int CTRL_MODE_LSB = 0;
    localparam int CTRL_IRQEN    = 2;
    localparam int CTRL_CLR      = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } chan_state_e;

endpackage

// File: rtl/counter_chan.sv
// One timer channel: down-counter with reload, mode/irq-enable control,
// sticky pending flag and the per-channel mode output.
module counter_chan
    import counter_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             tick,
    input  logic             load,
    input  logic             ctrl_wr,
    input  logic [CNT_W-1:0] data,
    output logic [CNT_W-1:0] count,
    output logic             cnt_out,
    output logic             pending,
    output logic             irq_en
);

    logic [CNT_W-1:0] count_reg, count_next;
    logic [CNT_W-1:0] reload_reg, reload_next;
    logic [1:0]       mode_reg, mode_next;
    logic             irq_en_reg, irq_en_next;
    logic             pending_reg, pending_next;
    logic             cnt_out_reg, cnt_out_next;
    chan_state_e      state_reg, state_next;
    logic [1:0]       wr_mode;

    assign wr_mode = data[CTRL_MODE_LSB +: 2];

    // Next-state: control write, then load (beats tick), then tick processing.
    // The pending set is applied last so a terminal event beats a clear.
    always_comb begin
        count_next   = count_reg;
        reload_next  = reload_reg;
        mode_next    = mode_reg;
        irq_en_next  = irq_en_reg;
        pending_next = pending_reg;
        cnt_out_next = cnt_out_reg;
        state_next   = state_reg;

        // Periodic output is a single-clock pulse
        if (mode_reg == MODE_PERIODIC) begin
            cnt_out_next = 1'b0;
        end

        if (ctrl_wr) begin
            mode_next   = wr_mode;
            irq_en_next = data[CTRL_IRQEN];
            if (data[CTRL_CLR]) begin
                pending_next = 1'b0;
            end
            if (wr_mode == MODE_STOP) begin
                if (state_reg == ST_RUN) begin
                    state_next = ST_IDLE;
                end
            end else if (state_reg == ST_IDLE) begin
                state_next = ST_RUN;
            end
        end

        if (load) begin
            count_next   = data;
            reload_next  = data;
            cnt_out_next = 1'b0;
            state_next   = (mode_next == MODE_STOP) ? ST_IDLE : ST_RUN;
        end else if (tick && (state_reg == ST_RUN) && (state_next == ST_RUN)) begin
            if (count_reg != '0) begin
                count_next = count_reg - 1'b1;
            end else begin
                pending_next = 1'b1;
                case (mode_next)
                    MODE_ONESHOT: begin
                        state_next   = ST_DONE;
                        cnt_out_next = 1'b1;
                    end
                    MODE_PERIODIC: begin
                        count_next   = reload_reg;
                        cnt_out_next = 1'b1;
                    end
                    MODE_SQUARE: begin
                        count_next   = reload_reg;
                        cnt_out_next = ~cnt_out_reg;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Channel state registers with asynchronous abort
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count_reg   <= '0;
            reload_reg  <= '0;
            mode_reg    <= MODE_ONESHOT;
            irq_en_reg  <= 1'b0;
            pending_reg <= 1'b0;
            cnt_out_reg <= 1'b0;
            state_reg   <= ST_IDLE;
        end else begin
            count_reg   <= count_next;
            reload_reg  <= reload_next;
            mode_reg    <= mode_next;
            irq_en_reg  <= irq_en_next;
            pending_reg <= pending_next;
            cnt_out_reg <= cnt_out_next;
            state_reg   <= state_next;
        end
    end

    assign count   = count_reg;
    assign cnt_out = cnt_out_reg;
    assign pending = pending_reg;
    assign irq_en  = irq_en_reg;

endmodule

// File: rtl/counter_nch.sv
// N-channel programmable timer/counter: tick synchronisers and edge
// detection, write decode, registered count readback and combined irq.
module counter_nch
    import counter_pkg::*;
#(
    parameter int NUM_CH = 3,
    parameter int CNT_W  = 32,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [NUM_CH-1:0] tick_i,
    input  logic              wr_en,
    input  logic              wr_reg,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [CNT_W-1:0]  wr_data,
    input  logic [CH_W-1:0]   rd_ch,
    output logic [CNT_W-1:0]  rd_data,
    output logic [NUM_CH-1:0] cnt_out,
    output logic              irq
);

    logic [NUM_CH-1:0] t1_reg, t2_reg, tick_edge_reg;
    logic [NUM_CH-1:0] load_vec, ctrl_vec, pending_vec, irq_en_vec;
    logic [CNT_W-1:0]  count_arr [NUM_CH];
    logic [CNT_W-1:0]  rd_sel, rd_data_reg;

    // Two-flop tick sampling; the rising-edge strobe is registered so a
    // rise sampled at edge k is counted at edge k+2
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            t1_reg        <= '0;
            t2_reg        <= '0;
            tick_edge_reg <= '0;
        end else begin
            t1_reg        <= tick_i;
            t2_reg        <= t1_reg;
            tick_edge_reg <= t1_reg & ~t2_reg;
        end
    end

    // Write decode per channel; out-of-range wr_ch matches no channel
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
            assign load_vec[gi] = wr_en & ~wr_reg & (wr_ch == CH_W'(gi));
            assign ctrl_vec[gi] = wr_en &  wr_reg & (wr_ch == CH_W'(gi));

            counter_chan #(
                .CNT_W (CNT_W)
            ) u_chan (
                .clk     (clk),
                .rstn    (rstn),
                .tick    (tick_edge_reg[gi]),
                .load    (load_vec[gi]),
                .ctrl_wr (ctrl_vec[gi]),
                .data    (wr_data),
                .count   (count_arr[gi]),
                .cnt_out (cnt_out[gi]),
                .pending (pending_vec[gi]),
                .irq_en  (irq_en_vec[gi])
            );
        end
    endgenerate

    // Readback select; unused channel indices read as zero
    always_comb begin
        rd_sel = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (rd_ch == CH_W'(i)) begin
                rd_sel = count_arr[i];
            end
        end
    end

    // Registered readback
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_data_reg <= '0;
        end else begin
            rd_data_reg <= rd_sel;
        end
    end

    assign rd_data = rd_data_reg;
    assign irq     = |(pending_vec & irq_en_vec);

endmodule

// File: tb/tb_counter_nch.sv
// Self-checking bench for counter_nch: a 4-channel 32-bit build and a
// 1-channel 8-bit build, checked against a tick-level behavioural model.
module tb_counter_nch;

    localparam int NCH    = 4;
    localparam int S_IDLE = 0;
    localparam int S_RUN  = 1;
    localparam int S_DONE = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rstn;
    logic [NCH-1:0] tick_i;
    logic           wr_en, wr_reg;
    logic [1:0]     wr_ch, rd_ch;
    logic [31:0]    wr_data, rd_data;
    logic [NCH-1:0] cnt_out;
    logic           irq;

    logic [0:0] s_tick, s_wr_ch, s_rd_ch, s_cnt_out;
    logic       s_wr_en, s_wr_reg, s_irq;
    logic [7:0] s_wr_data, s_rd_data;

    int checks = 0;
    int errors = 0;

    counter_nch #(.NUM_CH(NCH), .CNT_W(32)) dut (
        .clk(clk), .rstn(rstn), .tick_i(tick_i), .wr_en(wr_en), .wr_reg(wr_reg),
        .wr_ch(wr_ch), .wr_data(wr_data), .rd_ch(rd_ch), .rd_data(rd_data),
        .cnt_out(cnt_out), .irq(irq)
    );

    counter_nch #(.NUM_CH(1), .CNT_W(8)) dut_small (
        .clk(clk), .rstn(rstn), .tick_i(s_tick), .wr_en(s_wr_en), .wr_reg(s_wr_reg),
        .wr_ch(s_wr_ch), .wr_data(s_wr_data), .rd_ch(s_rd_ch), .rd_data(s_rd_data),
        .cnt_out(s_cnt_out), .irq(s_irq)
    );

    // Periodic pulse monitor on channel 1
    int pulse_cnt = 0;
    int wide_cnt  = 0;
    bit prev1     = 1'b0;
    always @(negedge clk) begin
        if (cnt_out[1] === 1'b1) begin
            pulse_cnt++;
            if (prev1) wide_cnt++;
        end
        prev1 = (cnt_out[1] === 1'b1);
    end

    // ---------------- behavioural model ----------------
    int unsigned m_count[NCH];
    int unsigned m_reload[NCH];
    int          m_mode[NCH];
    int          m_st[NCH];
    bit          m_pend[NCH], m_ien[NCH], m_out[NCH];

    function automatic void m_reset();
        for (int i = 0; i < NCH; i++) begin
            m_count[i] = 0; m_reload[i] = 0; m_mode[i] = 0; m_st[i] = S_IDLE;
            m_pend[i] = 0; m_ien[i] = 0; m_out[i] = 0;
        end
    endfunction

    function automatic void m_ctrl(int ch, int unsigned d);
        m_mode[ch] = int'(d % 4);
        m_ien[ch]  = ((d / 4) % 2) == 1;
        if (((d / 8) % 2) == 1) m_pend[ch] = 0;
        if (m_mode[ch] == 1) m_out[ch] = 0;
        if (m_mode[ch] == 3) begin
            if (m_st[ch] == S_RUN) m_st[ch] = S_IDLE;
        end else if (m_st[ch] == S_IDLE) begin
            m_st[ch] = S_RUN;
        end
    endfunction

    function automatic void m_load(int ch, int unsigned d);
        m_count[ch] = d; m_reload[ch] = d; m_out[ch] = 0;
        m_st[ch] = (m_mode[ch] == 3) ? S_IDLE : S_RUN;
    endfunction

    function automatic void m_tick(int ch);
        if (m_st[ch] != S_RUN) return;
        if (m_count[ch] > 0) begin
            m_count[ch] = m_count[ch] - 1;
            return;
        end
        m_pend[ch] = 1;
        if (m_mode[ch] == 0) begin
            m_st[ch] = S_DONE; m_out[ch] = 1;
        end else if (m_mode[ch] == 1) begin
            m_count[ch] = m_reload[ch]; m_out[ch] = 0;   // pulse already over
        end else begin
            m_count[ch] = m_reload[ch]; m_out[ch] = ~m_out[ch];
        end
    endfunction

    function automatic logic [NCH-1:0] m_out_vec();
        logic [NCH-1:0] v = '0;
        for (int i = 0; i < NCH; i++) v[i] = m_out[i];
        return v;
    endfunction

    function automatic logic m_irq();
        logic r = 1'b0;
        for (int i = 0; i < NCH; i++) r = r | (m_pend[i] & m_ien[i]);
        return r;
    endfunction

    // ---------------- stimulus helpers (called at a negedge) ----------------
    task automatic do_write(input int ch, input bit is_ctrl, input int unsigned d);
        wr_en = 1'b1; wr_reg = is_ctrl; wr_ch = 2'(ch); wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
        if (is_ctrl) m_ctrl(ch, d); else m_load(ch, d);
        $display("write ch=%0d ctrl=%0d data=0x%0h", ch, is_ctrl, d);
    endtask

    task automatic do_tick(input int ch);
        tick_i[ch] = 1'b1;
        @(negedge clk);
        tick_i[ch] = 1'b0;
        repeat (3) @(negedge clk);
        m_tick(ch);
        $display("tick ch=%0d model_count=%0d", ch, m_count[ch]);
    endtask

    task automatic read_cnt(input int ch, output int unsigned v);
        rd_ch = 2'(ch);
        @(negedge clk);
        v = rd_data;
    endtask

    task automatic s_write(input bit ch, input bit is_ctrl, input logic [7:0] d);
        s_wr_en = 1'b1; s_wr_reg = is_ctrl; s_wr_ch = ch; s_wr_data = d;
        @(negedge clk);
        s_wr_en = 1'b0;
    endtask

    task automatic s_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            s_tick = 1'b1; @(negedge clk);
            s_tick = 1'b0; @(negedge clk);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic s_read(output int unsigned v);
        s_rd_ch = 1'b0;
        @(negedge clk);
        v = s_rd_data;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int unsigned v;
        checks++;
        if (rd_data !== 32'd0 || cnt_out !== 4'd0 || irq !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: rd_data=%0h cnt_out=%b irq=%b expected 0/0000/0", rd_data, cnt_out, irq);
        end
        checks++;
        if (s_rd_data !== 8'd0 || s_cnt_out !== 1'b0 || s_irq !== 1'b0) begin
            errors++;
            $display("FAIL reset_small: rd_data=%0h cnt_out=%b irq=%b expected 0", s_rd_data, s_cnt_out, s_irq);
        end
        read_cnt(3, v);
        checks++;
        if (v !== 0) begin
            errors++;
            $display("FAIL reset_count: got %0d expected 0", v);
        end
    endtask

    task automatic test_oneshot();
        int unsigned v;
        do_write(0, 1'b1, 32'h4);
        do_write(0, 1'b0, 32'd3);
        for (int i = 1; i <= 3; i++) begin
            do_tick(0);
            read_cnt(0, v);
            checks++;
            if (v !== m_count[0] || v !== 32'(3 - i)) begin
                errors++;
                $display("FAIL oneshot_count: tick %0d got %0d expected %0d", i, v, 3 - i);
            end
        end
        // Fourth tick: terminal lands two clocks after the sampled rise
        tick_i[0] = 1'b1;
        @(negedge clk);
        tick_i[0] = 1'b0;
        checks++;
        if (cnt_out[0] !== 1'b0 || irq !== 1'b0) begin
            errors++;
            $display("FAIL oneshot_early1: cnt_out0=%b irq=%b expected 0/0", cnt_out[0], irq);
        end
        @(negedge clk);
        checks++;
        if (cnt_out[0] !== 1'b0 || irq !== 1'b0) begin
            errors++;
            $display("FAIL oneshot_early2: cnt_out0=%b irq=%b expected 0/0", cnt_out[0], irq);
        end
        @(negedge clk);
        m_tick(0);
        checks++;
        if (cnt_out[0] !== 1'b1 || irq !== 1'b1) begin
            errors++;
            $display("FAIL oneshot_terminal: cnt_out0=%b irq=%b expected 1/1", cnt_out[0], irq);
        end
        @(negedge clk);
        do_tick(0);
        do_tick(0);
        read_cnt(0, v);
        checks++;
        if (v !== 0 || cnt_out[0] !== 1'b1) begin
            errors++;
            $display("FAIL oneshot_hold: count=%0d cnt_out0=%b expected 0/1", v, cnt_out[0]);
        end
        do_write(0, 1'b1, 32'h8);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL oneshot_clear: irq=%b expected 0", irq);
        end
    endtask

    task automatic test_periodic();
        int unsigned v;
        int p0, w0;
        do_write(1, 1'b1, 32'h5);
        do_write(1, 1'b0, 32'd2);
        p0 = pulse_cnt;
        w0 = wide_cnt;
        for (int i = 0; i < 30; i++) do_tick(1);
        checks++;
        if (pulse_cnt - p0 != 10 || wide_cnt - w0 != 0) begin
            errors++;
            $display("FAIL periodic_pulses: pulses=%0d wide=%0d expected 10/0", pulse_cnt - p0, wide_cnt - w0);
        end
        read_cnt(1, v);
        checks++;
        if (v !== m_count[1] || v !== 2) begin
            errors++;
            $display("FAIL periodic_count: got %0d expected 2", v);
        end
        // Clear pending with irq_en kept: irq falls at the write edge
        wr_en = 1'b1; wr_reg = 1'b1; wr_ch = 2'd1; wr_data = 32'hD;
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL periodic_irq_before: irq=%b expected 1", irq);
        end
        @(negedge clk);
        wr_en = 1'b0;
        m_ctrl(1, 32'hD);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL periodic_irq_clear: irq=%b expected 0", irq);
        end
    endtask

    task automatic test_square();
        int unsigned v;
        do_write(2, 1'b1, 32'h2);
        do_write(2, 1'b0, 32'd0);
        for (int i = 1; i <= 4; i++) begin
            do_tick(2);
            checks++;
            if (cnt_out[2] !== m_out[2] || cnt_out[2] !== 1'(i % 2)) begin
                errors++;
                $display("FAIL square_toggle: tick %0d cnt_out2=%b expected %0d", i, cnt_out[2], i % 2);
            end
        end
        do_write(2, 1'b0, 32'd5);
        do_tick(2);
        do_tick(2);
        do_write(2, 1'b1, 32'h3);
        do_tick(2);
        do_tick(2);
        read_cnt(2, v);
        checks++;
        if (v !== 3) begin
            errors++;
            $display("FAIL square_stop: count=%0d expected 3", v);
        end
        do_write(2, 1'b1, 32'h2);
        do_tick(2);
        read_cnt(2, v);
        checks++;
        if (v !== 2 || v !== m_count[2]) begin
            errors++;
            $display("FAIL square_resume: count=%0d expected 2", v);
        end
    endtask

    task automatic test_collisions();
        int unsigned v;
        do_write(0, 1'b0, 32'd9);
        tick_i[0] = 1'b1;
        @(negedge clk);
        tick_i[0] = 1'b0;
        @(negedge clk);
        wr_en = 1'b1; wr_reg = 1'b0; wr_ch = 2'd0; wr_data = 32'd5;
        @(negedge clk);
        wr_en = 1'b0;
        m_load(0, 32'd5);
        repeat (2) @(negedge clk);
        read_cnt(0, v);
        checks++;
        if (v !== 5) begin
            errors++;
            $display("FAIL collide_load_tick: count=%0d expected 5", v);
        end
        do_write(3, 1'b1, 32'h5);
        do_write(3, 1'b0, 32'd0);
        do_tick(3);
        checks++;
        if (irq !== 1'b1 || irq !== m_irq()) begin
            errors++;
            $display("FAIL collide_pend_set: irq=%b expected 1", irq);
        end
        tick_i[3] = 1'b1;
        @(negedge clk);
        tick_i[3] = 1'b0;
        @(negedge clk);
        wr_en = 1'b1; wr_reg = 1'b1; wr_ch = 2'd3; wr_data = 32'hD;
        @(negedge clk);
        wr_en = 1'b0;
        m_ctrl(3, 32'hD);
        m_tick(3);
        @(negedge clk);
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL collide_clear_terminal: irq=%b expected 1", irq);
        end
        do_write(3, 1'b1, 32'hD);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL collide_plain_clear: irq=%b expected 0", irq);
        end
    endtask

    task automatic test_back_to_back();
        int unsigned v;
        do_write(3, 1'b0, 32'd7);
        tick_i[3] = 1'b1;
        @(negedge clk);
        tick_i[3] = 1'b0;
        @(negedge clk);
        wr_en = 1'b1; wr_reg = 1'b0; wr_ch = 2'd0; wr_data = 32'd11;
        @(negedge clk);
        wr_en = 1'b0;
        m_tick(3);
        m_load(0, 32'd11);
        repeat (2) @(negedge clk);
        read_cnt(3, v);
        checks++;
        if (v !== 6) begin
            errors++;
            $display("FAIL b2b_tick_ch3: count=%0d expected 6", v);
        end
        read_cnt(0, v);
        checks++;
        if (v !== 11) begin
            errors++;
            $display("FAIL b2b_load_ch0: count=%0d expected 11", v);
        end
    endtask

    task automatic test_random();
        int unsigned v, d;
        int ch, act;
        for (int n = 0; n < 40; n++) begin
            ch  = int'($urandom_range(0, NCH - 1));
            act = int'($urandom_range(0, 2));
            if (act == 0) begin
                d = $urandom_range(0, 4);
                do_write(ch, 1'b0, d);
            end else if (act == 1) begin
                d = $urandom_range(0, 15);
                do_write(ch, 1'b1, d);
            end else begin
                do_tick(ch);
            end
            read_cnt(ch, v);
            checks++;
            if (v !== m_count[ch]) begin
                errors++;
                $display("FAIL random_count: step %0d ch %0d got %0d expected %0d", n, ch, v, m_count[ch]);
            end
            checks++;
            if (cnt_out !== m_out_vec()) begin
                errors++;
                $display("FAIL random_cnt_out: step %0d got %b expected %b", n, cnt_out, m_out_vec());
            end
            checks++;
            if (irq !== m_irq()) begin
                errors++;
                $display("FAIL random_irq: step %0d got %b expected %b", n, irq, m_irq());
            end
        end
    endtask

    task automatic test_param();
        int unsigned v;
        s_write(1'b0, 1'b1, 8'h04);
        s_write(1'b0, 1'b0, 8'hFF);
        s_ticks(1);
        s_read(v);
        checks++;
        if (v !== 32'hFE) begin
            errors++;
            $display("FAIL param_first: count=%0h expected fe", v);
        end
        s_write(1'b1, 1'b0, 8'h10);
        s_write(1'b1, 1'b1, 8'h03);
        s_ticks(1);
        s_read(v);
        checks++;
        if (v !== 32'hFD) begin
            errors++;
            $display("FAIL param_ignored_ch: count=%0h expected fd", v);
        end
        s_ticks(253);
        s_read(v);
        checks++;
        if (v !== 0 || s_cnt_out !== 1'b0 || s_irq !== 1'b0) begin
            errors++;
            $display("FAIL param_255: count=%0h cnt_out=%b irq=%b expected 0/0/0", v, s_cnt_out, s_irq);
        end
        s_ticks(1);
        checks++;
        if (s_cnt_out !== 1'b1 || s_irq !== 1'b1) begin
            errors++;
            $display("FAIL param_256: cnt_out=%b irq=%b expected 1/1", s_cnt_out, s_irq);
        end
        s_ticks(1);
        s_read(v);
        checks++;
        if (v !== 0) begin
            errors++;
            $display("FAIL param_nowrap: count=%0h expected 0", v);
        end
    endtask

    task automatic test_async_reset();
        int unsigned v;
        do_write(2, 1'b1, 32'h6);
        do_write(2, 1'b0, 32'd0);
        do_tick(2);
        do_write(0, 1'b1, 32'h1);
        do_write(0, 1'b0, 32'd100);
        do_tick(0);
        do_tick(0);
        read_cnt(0, v);
        checks++;
        if (v !== 98 || cnt_out[2] !== 1'b1 || irq !== 1'b1) begin
            errors++;
            $display("FAIL areset_setup: count=%0d cnt_out2=%b irq=%b expected 98/1/1", v, cnt_out[2], irq);
        end
        #2;
        rstn = 1'b0;
        #1;
        checks++;
        if (rd_data !== 32'd0 || cnt_out !== 4'd0 || irq !== 1'b0 || s_cnt_out !== 1'b0) begin
            errors++;
            $display("FAIL areset_async: rd_data=%0d cnt_out=%b irq=%b expected 0/0000/0", rd_data, cnt_out, irq);
        end
        @(negedge clk);
        rstn = 1'b1;
        m_reset();
        read_cnt(0, v);
        checks++;
        if (v !== 0 || v !== m_count[0]) begin
            errors++;
            $display("FAIL areset_count: count=%0d expected 0", v);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time budget exceeded before completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rstn = 1'b0; tick_i = '0; wr_en = 1'b0; wr_reg = 1'b0; wr_ch = '0; wr_data = '0; rd_ch = '0;
        s_tick = '0; s_wr_en = 1'b0; s_wr_reg = 1'b0; s_wr_ch = '0; s_wr_data = '0; s_rd_ch = '0;
        m_reset();
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        test_reset();
        test_oneshot();
        test_periodic();
        test_square();
        test_collisions();
        test_back_to_back();
        test_random();
        test_param();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/counter_nch.md
# counter_nch

Parametrised N-channel programmable timer/counter for the SCPU system, succeeding the fixed three-channel down-counter. It sits on the CPU peripheral bus beside the GPIO and display blocks, counts rising edges of per-channel tick sources from the clock divider, and supports one-shot, periodic-pulse and square-wave modes. It adds per-channel interrupt enable, sticky pending flags, registered count readback and a single combined interrupt for the CPU `INT` input.

## Interface
- `NUM_CH`, default 3: number of channels, 1..8.
- `CNT_W`, default 32: counter and reload width, 8..32.
- `CH_W`, default `$clog2(NUM_CH)` (minimum 1): channel select width.
- `clk`, in, 1: system clock. Single clock domain for the whole block.
- `rstn`, in, 1: asynchronous, active-low reset.
- `tick_i`, in, `NUM_CH`: per-channel count source level, for example a `clkdiv` bit. Rising edges are counted.
- `wr_en`, in, 1: register write strobe, one cycle.
- `wr_reg`, in, 1: write target. 0 = load/reload value; 1 = control.
- `wr_ch`, in, `CH_W`: channel to write.
- `wr_data`, in, `CNT_W`: write data. Control uses bits [3:0].
- `rd_ch`, in, `CH_W`: channel whose current count is returned.
- `rd_data`, out, `CNT_W`: registered count of `rd_ch`.
- `cnt_out`, out, `NUM_CH`: per-channel mode output.
- `irq`, out, 1: OR over channels of (pending & irq_en).

## Operation
- Control bits: [1:0] mode (0 one-shot, 1 periodic, 2 square, 3 stop); [2] irq_en; [3] clear pending. Bit [3] is write-1-to-clear and is not stored. A control write does not alter `count`.
- Per-channel state: IDLE, RUN, DONE.
- Load write: sets `reload` = `count` = `wr_data`. Next state is RUN, or IDLE if mode = stop. `cnt_out` is cleared to 0.
- Tick edge in RUN:
  - count ≠ 0: decrement by 1.
  - count = 0 is the terminal event. It sets pending, then by mode:
    - one-shot: go to DONE, `cnt_out` = 1 and held.
    - periodic: `count` = `reload`, `cnt_out` high for exactly one clk.
    - square: `count` = `reload`, `cnt_out` toggles.
- Count never wraps below 0. Reload 0 means a terminal event on every tick.
- Ticks are ignored in IDLE and DONE.
- Writing mode = stop in RUN moves the channel to IDLE and freezes `count`. Writing a running mode while IDLE resumes from the held `count`.
- Writes with `wr_ch` ≥ `NUM_CH` are ignored.
- Simultaneous events:
  - load and tick on the same channel: load wins, the tick is dropped.
  - pending clear and terminal event: set wins.
  - writes and ticks on different channels are independent.
- Reset values: `count`, `reload`, ctrl = 0; state IDLE; pending 0; `cnt_out` = 0; `rd_data` = 0; `irq` = 0. Asserting reset mid-count aborts immediately and asynchronously.

## Timing
- `tick_i` passes through two flops (t1, t2). Edge = t1 & ~t2.
- A `tick_i` rise sampled at clk edge k updates `count` at edge k+2.
- A tick high for fewer than one clk period may be missed. Sources must be at least one clk period high and one low.
- Load and control writes take effect at the clk edge sampling `wr_en`.
- `rd_data` is registered: `rd_ch` at edge k gives that channel's post-edge-k count at edge k+1.
- `irq` and `cnt_out` are driven directly from registers, with no extra latency after the terminal edge.
- Periodic-mode pulse width is exactly one clk.

## Structure
- Package `counter_pkg`:
  - mode encoding constants: MODE_ONESHOT, MODE_PERIODIC, MODE_SQUARE, MODE_STOP.
  - control bit positions: CTRL_MODE_LSB, CTRL_IRQEN, CTRL_CLR.
  - channel state enum: ST_IDLE, ST_RUN, ST_DONE.
- Sub-module `counter_chan`: one channel. Holds `count`, `reload`, ctrl, state, pending and `cnt_out`. Inputs are tick edge, load strobe, control strobe and data.
- Top level:
  - generates `NUM_CH` instances of `counter_chan`.
  - per-channel tick synchronisers and edge detectors.
  - write decode.
  - readback mux register.
  - `irq` OR reduction.

## Test plan
- Reset: assert `rstn` = 0 mid-count -> all outputs 0 asynchronously; `count` reads 0 after release.
- One-shot: ch0 mode 0, irq_en = 1, load 3, four tick rises -> `rd_data` reads 2, 1, 0. `cnt_out[0]` and `irq` go to 1 two clks after the 4th tick rise. Further ticks leave `count` at 0.
- Periodic: ch1 load 2, mode 1 -> `cnt_out[1]` is a 1-clk pulse every 3rd tick, 10 pulses over 30 ticks. Pending clear with irq_en = 1 drops `irq` the next edge.
- Square: ch2 (`NUM_CH` = 4 build) load 0, mode 2 -> `cnt_out[2]` toggles on every tick. Stop mode freezes the count; re-enable resumes from the same value.
- Collisions: load 5 in the same clk as a tick edge -> `count` = 5, not 4. Clear in the same clk as a terminal event -> pending stays 1.
- Parametrisation: `NUM_CH` = 1, `CNT_W` = 8, load 8'hFF -> terminal after 256 ticks with no wrap. Write with `wr_ch` = 1 is ignored.
